// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a FIFO with a registered read port and presents
// its contents as a valid/ready stream. A 3-entry skid buffer covers the
// one-cycle read latency so one word per cycle can be sustained. FIFO read
// requests depend only on registered state, never on m_ready.
//
// Stream handshake: a word transfers on every rising edge where m_valid and
// m_ready are both high. Once m_valid is raised it stays high, with m_data
// held stable, until that transfer happens (only rst may drop it). m_ready
// may change freely and m_valid never depends on it.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_read_en,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  idle
);

  // Read accepted by the FIFO last cycle; its data arrives this cycle.
  logic                  inflight;
  logic [DATA_WIDTH-1:0] buf_mem [3];
  logic [1:0]            wp;
  logic [1:0]            rp;
  logic [1:0]            buf_count;
  logic [2:0]            occupancy;
  logic                  pop;

  // Pointers step 0 -> 1 -> 2 -> 0; the value 3 is never used.
  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Words already owned by this block: buffered plus the one in flight.
  // A new read is only issued when that total leaves a free entry, so the
  // unconditional capture below can never overflow.
  assign occupancy    = {1'b0, buf_count} + {2'b00, inflight};
  assign fifo_read_en = !rst && enable && !fifo_empty && (occupancy < 3'd3);

  // Stream side: head of the buffer. m_data is forced to zero while empty
  // so the output is clean after reset.
  assign m_valid = (buf_count != 2'd0);
  assign m_data  = m_valid ? buf_mem[rp] : '0;
  assign pop     = m_valid && m_ready;
  assign idle    = !m_valid && !inflight && fifo_empty;

  // Control state: in-flight flag, pointers, fill level and word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight   <= 1'b0;
      wp         <= 2'd0;
      rp         <= 2'd0;
      buf_count  <= 2'd0;
      word_count <= '0;
    end else begin
      inflight <= fifo_read_en;
      if (inflight) begin
        wp <= next_ptr(wp);
      end
      if (pop) begin
        rp         <= next_ptr(rp);
        word_count <= word_count + 1'b1;
      end
      buf_count <= buf_count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  // Data path: capture the FIFO's registered read data one cycle after the read.
  always_ff @(posedge clk) begin
    if (inflight) begin
      buf_mem[wp] <= fifo_read_data;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader. A queue-based FIFO with a registered read
// port feeds the DUT. A per-cycle reference model tracks the words the DUT
// has read but not yet delivered, and derives every expected output from it.
// Directed scenarios add hand-computed literal expectations on top.
module tb_fifo_stream_reader;
  localparam int W  = 4;
  localparam int CW = 16;

  // ---------------- clock / reset / DUT signals ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_read_en;
  logic [W-1:0]  fifo_read_data = '0;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic          m_ready = 1'b0;
  logic [CW-1:0] word_count;
  logic          idle;

  // FIFO write side and clear, driven by the stimulus process.
  logic          push_en = 1'b0;
  logic [W-1:0]  push_data = '0;
  logic          fifo_clr = 1'b0;
  logic [W-1:0]  fifo_q[$];

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_read_en   (fifo_read_en),
    .fifo_read_data (fifo_read_data),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_ready        (m_ready),
    .word_count     (word_count),
    .idle           (idle)
  );

  // Source FIFO: registered read data, empty flag reflects contents after the edge.
  always @(posedge clk) begin
    if (fifo_clr) begin
      fifo_q.delete();
      fifo_read_data <= '0;
    end else begin
      if (fifo_read_en && fifo_q.size() > 0) fifo_read_data <= fifo_q.pop_front();
      if (push_en) fifo_q.push_back(push_data);
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0]  exp_q[$];      // words read from the FIFO, not yet delivered
  int            exp_cyc_q[$];  // cycle in which each of those words was read
  logic [CW-1:0] exp_count = '0;
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  logic          exp_rd;
  logic          exp_valid;

  // Literal expectations posted by the stimulus process, checked by the compare process.
  string         lit_name [128];
  logic [31:0]   lit_act  [128];
  logic [31:0]   lit_exp  [128];
  int            lit_wr = 0;
  int            lit_rd = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: each cycle, outputs against the model, then advance the model.
  always @(negedge clk) begin
    while (lit_rd < lit_wr) begin
      cmp(lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
      lit_rd++;
    end
    // At most 3 words may be owned at once; a read is visible 2 cycles later.
    exp_rd    = !rst && enable && !fifo_empty && (exp_q.size() < 3);
    exp_valid = (exp_q.size() > 0) && (exp_cyc_q[0] + 2 <= cyc);
    cmp("read_en", 32'(fifo_read_en), 32'(exp_rd));
    cmp("m_valid", 32'(m_valid), 32'(exp_valid));
    cmp("word_count", 32'(word_count), 32'(exp_count));
    cmp("idle", 32'(idle), 32'((exp_q.size() == 0) && fifo_empty));
    if (exp_valid) begin
      cmp("m_data", 32'(m_data), 32'(exp_q[0]));
      if (m_ready) begin
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
        exp_count = exp_count + 1'b1;
      end
    end
    if (exp_rd && fifo_q.size() > 0) begin
      exp_q.push_back(fifo_q[0]);
      exp_cyc_q.push_back(cyc);
    end
    if (rst) begin
      exp_q.delete();
      exp_cyc_q.delete();
      exp_count = '0;
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (lit_wr < 128) begin
      lit_name[lit_wr] = name;
      lit_act[lit_wr]  = act;
      lit_exp[lit_wr]  = exp;
      lit_wr++;
    end
  endtask

  task automatic push(input logic [W-1:0] d);
    push_en   = 1'b1;
    push_data = d;
    step();
    push_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fifo_clr = 1'b1;
    step();
    step();
    rst = 1'b0;
    fifo_clr = 1'b0;
    #1;
  endtask

  task automatic wait_idle(input int max, input string name);
    int n;
    n = 0;
    while (!idle && n < max) begin
      step();
      n++;
    end
    lit(name, 32'(idle), 32'd1);
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int           rds;
    int           nv;
    logic [W-1:0] seq [8];
    int           vi  [8];

    // 1. Reset with the FIFO holding data.
    rst = 1'b1; enable = 1'b1; m_ready = 1'b1;
    step();
    push(4'h1); push(4'h2); push(4'h3);
    lit("t1_rst_valid", 32'(m_valid), 32'd0);
    lit("t1_rst_rd", 32'(fifo_read_en), 32'd0);
    lit("t1_rst_count", 32'(word_count), 32'd0);
    lit("t1_rst_data", 32'(m_data), 32'd0);
    rst = 1'b0;
    #1;
    lit("t1_rd_after_rst", 32'(fifo_read_en), 32'd1);
    wait_idle(30, "t1_idle");
    lit("t1_count", 32'(word_count), 32'd3);

    // 2. Single word.
    do_reset();
    enable = 1'b1; m_ready = 1'b1;
    step();
    push(4'hA);
    lit("t2_rd_pulse", 32'(fifo_read_en), 32'd1);
    lit("t2_valid_early", 32'(m_valid), 32'd0);
    step();
    lit("t2_rd_once", 32'(fifo_read_en), 32'd0);
    lit("t2_valid_n1", 32'(m_valid), 32'd0);
    step();
    lit("t2_valid", 32'(m_valid), 32'd1);
    lit("t2_data", 32'(m_data), 32'hA);
    step();
    lit("t2_count", 32'(word_count), 32'd1);
    lit("t2_idle", 32'(idle), 32'd1);

    // 3. Streaming 1..4 with m_ready held high.
    do_reset();
    enable = 1'b0; m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push(W'(i));
    enable = 1'b1;
    #1;
    rds = 0; nv = 0;
    for (int i = 0; i < 10; i++) begin
      rds += int'(fifo_read_en);
      if (m_valid && nv < 8) begin seq[nv] = m_data; vi[nv] = i; nv++; end
      step();
    end
    lit("t3_reads", 32'(rds), 32'd4);
    lit("t3_nvalid", 32'(nv), 32'd4);
    for (int k = 0; k < 4; k++) lit("t3_order", 32'(seq[k]), 32'(k + 1));
    lit("t3_first_at", 32'(vi[0]), 32'd2);
    lit("t3_back_to_back", 32'(vi[3] - vi[0]), 32'd3);
    lit("t3_count", 32'(word_count), 32'd4);

    // 4. Backpressure, then release.
    do_reset();
    enable = 1'b0; m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(W'(i));
    enable = 1'b1;
    #1;
    rds = 0;
    for (int i = 0; i < 10; i++) begin
      rds += int'(fifo_read_en);
      step();
    end
    lit("t4_reads", 32'(rds), 32'd3);
    lit("t4_rd_stalled", 32'(fifo_read_en), 32'd0);
    lit("t4_valid_held", 32'(m_valid), 32'd1);
    lit("t4_data_held", 32'(m_data), 32'h1);
    m_ready = 1'b1;
    #1;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      if (m_valid && nv < 8) begin seq[nv] = m_data; nv++; end
      step();
    end
    lit("t4_nvalid", 32'(nv), 32'd4);
    for (int k = 0; k < 4; k++) lit("t4_order", 32'(seq[k]), 32'(k + 1));
    lit("t4_count", 32'(word_count), 32'd4);

    // 5. Enable falls right after a read pulse; in-flight word still delivered.
    do_reset();
    enable = 1'b1; m_ready = 1'b1;
    step();
    push(4'h5);
    lit("t5_rd", 32'(fifo_read_en), 32'd1);
    step();
    enable = 1'b0;
    #1;
    rds = 0; nv = 0;
    for (int i = 0; i < 8; i++) begin
      push_en   = (i < 2);
      push_data = W'(6 + i);
      rds += int'(fifo_read_en);
      if (m_valid && nv < 8) begin seq[nv] = m_data; nv++; end
      step();
    end
    push_en = 1'b0;
    lit("t5_no_reads", 32'(rds), 32'd0);
    lit("t5_nvalid", 32'(nv), 32'd1);
    lit("t5_inflight_word", 32'(seq[0]), 32'h5);
    enable = 1'b1;
    wait_idle(30, "t5_idle");
    lit("t5_count", 32'(word_count), 32'd3);

    // 6. Seven words with toggling m_ready, then reset with two words buffered.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 27; i++) begin
      m_ready   = (i % 2 == 0);
      push_en   = (i < 7);
      push_data = W'($urandom_range(0, 15));
      step();
    end
    push_en = 1'b0;
    lit("t6_count", 32'(word_count), 32'd7);
    lit("t6_idle", 32'(idle), 32'd1);
    m_ready = 1'b0;
    push(4'h8);
    push(4'h9);
    for (int i = 0; i < 4; i++) step();
    lit("t6_pre_rst_valid", 32'(m_valid), 32'd1);
    lit("t6_pre_rst_data", 32'(m_data), 32'h8);
    do_reset();
    lit("t6_rst_valid", 32'(m_valid), 32'd0);
    lit("t6_rst_count", 32'(word_count), 32'd0);
    lit("t6_rst_data", 32'(m_data), 32'd0);

    // 7. Randomized pushes, enable and m_ready against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      push_en   = ($urandom_range(0, 2) != 0);
      push_data = W'($urandom_range(0, 15));
      enable    = ($urandom_range(0, 7) != 0);
      m_ready   = ($urandom_range(0, 3) != 0);
      step();
    end
    push_en = 1'b0; enable = 1'b1; m_ready = 1'b1;
    wait_idle(1000, "t7_idle");

    step();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side adapter that drains a synchronous FIFO with a registered read port (`read_data` valid the cycle after an accepted `read_en`). It presents the FIFO contents as a valid/ready stream. It sits between any of the team's FIFOs and a downstream consumer. Read requests depend only on registered state, so there is no combinational path from `m_ready` to `fifo_read_en`. A 3-entry skid buffer absorbs read latency and sustains one word per cycle.

## Interface
- `DATA_WIDTH`, default 4: FIFO and stream data width.
- `CNT_WIDTH`, default 16: width of the delivered-word counter.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `enable`  in  1  when high, the block may issue FIFO reads.
- `fifo_empty`  in  1  empty flag from the FIFO.
- `fifo_read_en`  out  1  read request to the FIFO.
- `fifo_read_data`  in  DATA_WIDTH  FIFO registered read data.
- `m_valid`  out  1  stream data valid.
- `m_data`  out  DATA_WIDTH  stream data.
- `m_ready`  in  1  consumer accepts `m_data` when high together with `m_valid`.
- `word_count`  out  CNT_WIDTH  number of stream handshakes since reset, wraps modulo 2^CNT_WIDTH.
- `idle`  out  1  high when no data is buffered, nothing is in flight, and `fifo_empty` is high.

## Operation
**State**
- `inflight`, 1 bit: set to the value of `fifo_read_en` in the previous cycle.
- Buffer of 3 entries, each DATA_WIDTH bits.
- Write pointer `wp` and read pointer `rp`, 2 bits each, counting 0→1→2→0. The value 3 is never reached.
- `buf_count` in 0..3.

**Read issue (combinational)**
- `fifo_read_en = enable && !fifo_empty && (buf_count + inflight < 3)`.
- The sum is evaluated as a 3-bit quantity.
- No term depends on `m_ready` or `m_valid`.

**Capture**
- When `inflight` is 1, `fifo_read_data` is written to `buf[wp]` and `wp` advances.
- Capture is unconditional. The issue rule guarantees a free entry, so overflow cannot occur.

**Output**
- `m_valid = (buf_count != 0)`.
- `m_data = buf[rp]`; its value is don't-care when `m_valid` is 0.
- A pop occurs when `m_valid && m_ready`. On a pop, `rp` advances and `word_count` increments.

**Count update**
- `buf_count` next = `buf_count + inflight - pop`.
- Capture and pop in the same cycle leave `buf_count` unchanged.

**Behaviour when `enable` is low**
- No new reads are issued.
- An in-flight word is still captured.
- Buffered words continue to drain to the stream.

**Ordering**
- Words appear on `m_data` strictly in FIFO order.
- No word is dropped or duplicated.

**Reset**
- `inflight`, `wp`, `rp`, `buf_count` and `word_count` are cleared to 0.
- Resulting output values: `m_valid`=0, `m_data`=0, `word_count`=0.
- `idle` equals `fifo_empty`.
- `fifo_read_en` is 0 while `rst` is high.
- Reset mid-operation discards buffered and in-flight words. The FIFO must be reset in the same cycle; the integration rule is one shared `rst`.

## Timing
- **Latency:** if `fifo_read_en` is high in cycle N, the word is captured at the end of cycle N+1 and `m_valid` shows it in cycle N+2. There is no bypass path.
- **First word:** if `fifo_empty` falls in cycle T and the buffer is empty, `fifo_read_en` goes high in cycle T and `m_valid` rises in cycle T+2.
- **Throughput:** with `m_ready` held at 1 and the FIFO non-empty, `fifo_read_en` stays high every cycle and `m_valid` stays high every cycle after the initial 2-cycle fill. The rate is one word per cycle.
- **Backpressure:** with `m_ready`=0, the buffer fills to 3 and `fifo_read_en` drops. At most 3 words are held (buffered plus in flight).
- When `m_ready` returns to 1, `fifo_read_en` reasserts in the cycle after the first pop.
- **Stream rules:**
  - `m_valid` never falls without a handshake, except on reset.
  - `m_data` is stable while `m_valid && !m_ready`.
- **Pointer wrap:** a pointer at 2 goes to 0. `buf_count` saturates structurally at 3.

## Test plan
1. **Reset:** assert `rst` for 2 cycles with the FIFO holding data.
   - Required: `m_valid`=0, `fifo_read_en`=0 and `word_count`=0 during reset.
   - Required: `fifo_read_en`=1 in the first cycle after reset.
2. **Single word:** FIFO is written 0xA.
   - Required: `fifo_read_en` pulses for 1 cycle and `m_valid` rises 2 cycles later with `m_data`=0xA.
   - Required: after the pop, `word_count`=1 and `idle`=1.
3. **Streaming:** FIFO is preloaded with 0x1..0x4 (depth 4) and `m_ready` is held at 1.
   - Required: `m_data` = 0x1, 0x2, 0x3, 0x4 on 4 consecutive cycles and `word_count`=4.
   - Required: `fifo_read_en` is high for exactly 4 cycles.
4. **Backpressure:** FIFO is holding 0x1..0x4 and `m_ready`=0 for 10 cycles.
   - Required: `buf_count` reaches 3, `fifo_read_en` stays 0 after the 3rd read, and `m_data` holds 0x1.
   - Then raise `m_ready`. Required: 0x1..0x4 are delivered in order and no word is lost.
5. **Enable gating:** `enable` falls in the same cycle as a `fifo_read_en` pulse.
   - Required: the in-flight word is still delivered.
   - Required: no further reads occur until `enable`=1.
6. **Mid-stream reset and wrap:** stream 7 words with `m_ready` toggling 1,0,1,0, then apply `rst` while `buf_count`=2.
   - Required: all pointer wraps keep the 7 words in order.
   - Required: after reset, `m_valid`=0 and `word_count`=0.
